// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: turns single-byte CPU memory requests into complete SPI memory
// transactions (command, address MSB first, data) driven one byte at a time
// through an upstream SPI byte engine. Owns the device chip select.
// Optional build macro SPI_MEM_WREN_EN: each write is preceded by a separate
// WREN (0x06) chip-select frame.
module spi_mem_ctrl #(
  parameter int unsigned ADDR_BYTES = 2,
  parameter int unsigned CS_HOLD    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [ADDR_BYTES*8-1:0] mem_addr,
  input  logic [7:0]              mem_wdata,
  output logic [7:0]              mem_rdata,
  output logic                    mem_ready,
  output logic                    busy,
  output logic                    spi_cs_n,
  output logic [7:0]              spi_data_tx,
  output logic                    spi_txn_start,
  input  logic [7:0]              spi_data_rx,
  input  logic                    spi_txn_done
);

  localparam int unsigned LastIdx = ADDR_BYTES + 1;

  typedef enum logic [3:0] {
    StIdle,
    StCsSetup,
    StIssue,
    StWait,
    StCsHold,
    StDone
`ifdef SPI_MEM_WREN_EN
    ,
    StWrenIssue,
    StWrenWait,
    StWrenGap
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    first_q, first_d;
  logic                    we_q, we_d;
  logic [ADDR_BYTES*8-1:0] addr_q, addr_d;
  logic [7:0]              wdata_q, wdata_d;
  logic [7:0]              rdata_q, rdata_d;
  logic [7:0]              tx_q, tx_d;
  logic [ADDR_BYTES*8-1:0] addr_shift;
  logic [7:0]              cur_byte;
`ifdef SPI_MEM_WREN_EN
  logic                    wren_done_q, wren_done_d;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done is stale in the first cycle after a start pulse
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (mem_req && spi_txn_done) state_d = StCsSetup;
      StCsSetup: begin
`ifdef SPI_MEM_WREN_EN
        if (we_q && !wren_done_q) state_d = StWrenIssue;
        else                      state_d = StIssue;
`else
        state_d = StIssue;
`endif
      end
      StIssue:   state_d = StWait;
      StWait: begin
        if (!first_q && spi_txn_done) begin
          state_d = (idx_q == 3'(LastIdx)) ? StCsHold : StIssue;
        end
      end
      StCsHold:  if (cnt_q == 4'd1) state_d = StDone;
      StDone:    state_d = StIdle;
`ifdef SPI_MEM_WREN_EN
      StWrenIssue: state_d = StWrenWait;
      StWrenWait:  if (!first_q && spi_txn_done) state_d = StWrenGap;
      StWrenGap:   if (cnt_q == 4'd1) state_d = StCsSetup;
`endif
      default:   state_d = StIdle;
    endcase
  end

  // Datapath registers: request latch, byte index, hold counter, tx/rx bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= 3'd0;
      cnt_q       <= 4'd0;
      first_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      tx_q        <= 8'h00;
`ifdef SPI_MEM_WREN_EN
      wren_done_q <= 1'b0;
`endif
    end else begin
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      tx_q        <= tx_d;
`ifdef SPI_MEM_WREN_EN
      wren_done_q <= wren_done_d;
`endif
    end
  end

  // Datapath next values; tx byte is loaded on entry to ISSUE so it is valid with the start pulse
  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tx_d    = tx_q;
    first_d = (state_q == StIssue);
`ifdef SPI_MEM_WREN_EN
    wren_done_d = wren_done_q;
    if (state_q == StWrenIssue) first_d = 1'b1;
`endif

    if (state_q == StIdle && state_d == StCsSetup) begin
      we_d    = mem_we;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      idx_d   = 3'd0;
`ifdef SPI_MEM_WREN_EN
      wren_done_d = 1'b0;
`endif
    end

    if (state_q == StWait && state_d == StIssue) idx_d = idx_q + 3'd1;

    // Byte for the index about to be issued
    addr_shift = addr_q >> (8 * (ADDR_BYTES - 32'(idx_d)));
    if (idx_d == 3'd0)               cur_byte = we_q ? 8'h02 : 8'h03;
    else if (idx_d == 3'(LastIdx))   cur_byte = we_q ? wdata_q : 8'h00;
    else                             cur_byte = addr_shift[7:0];

    if (state_d == StIssue && state_q != StIssue) tx_d = cur_byte;

    if (state_d == StCsHold && state_q != StCsHold) begin
      cnt_d = 4'(CS_HOLD);
    end else if (state_q == StCsHold) begin
      cnt_d = cnt_q - 4'd1;
    end

    if (state_q == StWait && state_d == StCsHold && !we_q) rdata_d = spi_data_rx;

`ifdef SPI_MEM_WREN_EN
    if (state_d == StWrenIssue && state_q != StWrenIssue) tx_d = 8'h06;
    if (state_q == StWrenWait && state_d == StWrenGap) begin
      wren_done_d = 1'b1;
      cnt_d       = 4'(CS_HOLD);
    end else if (state_q == StWrenGap) begin
      cnt_d = cnt_q - 4'd1;
    end
`endif
  end

  // Outputs decoded from the current state; chip select low for the whole frame
  always_comb begin
    spi_cs_n      = 1'b1;
    spi_txn_start = 1'b0;
    unique case (state_q)
      StCsSetup, StWait: spi_cs_n = 1'b0;
      StIssue: begin
        spi_cs_n      = 1'b0;
        spi_txn_start = 1'b1;
      end
`ifdef SPI_MEM_WREN_EN
      StWrenWait: spi_cs_n = 1'b0;
      StWrenIssue: begin
        spi_cs_n      = 1'b0;
        spi_txn_start = 1'b1;
      end
`endif
      default: ;
    endcase
    mem_ready   = (state_q == StDone);
    busy        = (state_q != StIdle);
    spi_data_tx = tx_q;
    mem_rdata   = rdata_q;
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Testbench for spi_mem_ctrl with a small spi_core behavioural model and a
// transaction-level reference (expected byte stream / frames / read data).
module tb_spi_mem_ctrl;
  localparam int unsigned AB = 2;
  localparam int unsigned CH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [AB*8-1:0] mem_addr = '0;
  logic [7:0]    mem_wdata = 8'h00;
  logic [7:0]    mem_rdata;
  logic          mem_ready, busy, spi_cs_n, spi_txn_start;
  logic [7:0]    spi_data_tx;
  logic [7:0]    spi_data_rx;
  logic          spi_txn_done;

  int passed = 0;
  int fails = 0;
  int total = 0;

  always #5 clk = ~clk;

  spi_mem_ctrl #(.ADDR_BYTES(AB), .CS_HOLD(CH)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy),
    .spi_cs_n(spi_cs_n), .spi_data_tx(spi_data_tx), .spi_txn_start(spi_txn_start),
    .spi_data_rx(spi_data_rx), .spi_txn_done(spi_txn_done)
  );

  // spi_core model: done stays high (stale) one cycle after start, then low lat_cfg cycles.
  // Each byte of a frame returns key + its position in the frame.
  int         lat_cfg = 2;
  logic       hold_low = 1'b0;
  logic [7:0] key = 8'h00;
  logic       pend;
  int         sc_cnt;
  int         pos;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0; sc_cnt <= 0; spi_data_rx <= 8'h00; pos <= 0;
    end else begin
      if (spi_cs_n) pos <= 0;
      pend <= spi_txn_start;
      if (pend) begin
        sc_cnt      <= lat_cfg;
        spi_data_rx <= key + 8'(pos);
        pos         <= pos + 1;
      end else if (sc_cnt != 0) begin
        sc_cnt <= sc_cnt - 1;
      end
    end
  end
  assign spi_txn_done = (sc_cnt == 0) && !hold_low;

  // Bus monitor
  logic [7:0] tx_q[$];
  int         fr_q[$];
  int         frame_no = 0;
  int         bad_start = 0;
  int         ready_cnt = 0;
  int         ready_hi = 0;
  int         hi_run = 0;
  logic       prev_cs = 1'b1;

  always @(negedge clk) begin
    if (prev_cs && !spi_cs_n) frame_no++;
    if (spi_txn_start) begin
      tx_q.push_back(spi_data_tx);
      fr_q.push_back(frame_no);
      if (spi_cs_n) bad_start++;
    end
    if (mem_ready) begin
      ready_cnt++;
      ready_hi = hi_run;
    end
    hi_run  = spi_cs_n ? hi_run + 1 : 0;
    prev_cs = spi_cs_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    @(posedge clk);
    tx_q.delete(); fr_q.delete(); frame_no = 0; ready_cnt = 0; bad_start = 0;
  endtask

  task automatic wait_ready(input string tag, input int bound);
    logic got;
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (mem_ready) begin got = 1'b1; break; end
    end
    chk({tag, " ready seen"}, 32'(got), 32'd1);
  endtask

  // Reference: expected byte stream and frame numbers for one request, starting at frame base
  task automatic check_stream(input string tag, input logic we, input logic [AB*8-1:0] addr,
                              input logic [7:0] wd, input int base);
    logic [7:0] eb[$];
    int         ef[$];
    int         f;
    f = base;
`ifdef SPI_MEM_WREN_EN
    if (we) begin eb.push_back(8'h06); ef.push_back(f); f++; end
`endif
    eb.push_back(we ? 8'h02 : 8'h03); ef.push_back(f);
    for (int i = AB - 1; i >= 0; i--) begin eb.push_back(addr[8*i +: 8]); ef.push_back(f); end
    eb.push_back(we ? wd : 8'h00); ef.push_back(f);
    for (int i = 0; i < eb.size(); i++) begin
      chk($sformatf("%s byte%0d", tag, i), (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hdead,
          32'(eb[i]));
      chk($sformatf("%s frame%0d", tag, i), (i < fr_q.size()) ? 32'(fr_q[i]) : 32'hdead,
          32'(ef[i]));
    end
  endtask

  logic [7:0] exp_rdata = 8'h00;

  task automatic run_txn(input string tag, input logic we, input logic [AB*8-1:0] addr,
                         input logic [7:0] wd, input int lat, input logic [7:0] k);
    clear_logs();
    lat_cfg = lat;
    key     = k;
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
    @(negedge clk);
    // Garbage while busy must be ignored
    mem_req = 1'b0; mem_we = 1'($urandom); mem_addr = AB*8'($urandom);
    mem_wdata = 8'($urandom);
    wait_ready(tag, 2000);
    if (!we) exp_rdata = k + 8'(AB + 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    chk({tag, " nbytes"}, 32'(tx_q.size()), we ? 32'(AB + 2 + (`ifdef SPI_MEM_WREN_EN 1 `else 0 `endif))
                                              : 32'(AB + 2));
    check_stream(tag, we, addr, wd, 1);
    chk({tag, " ready pulses"}, 32'(ready_cnt), 32'd1);
    chk({tag, " cs high before ready"}, 32'(ready_hi), 32'(CH));
    chk({tag, " rdata"}, 32'(mem_rdata), 32'(exp_rdata));
    chk({tag, " start with cs high"}, 32'(bad_start), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset cs_n", 32'(spi_cs_n), 32'd1);
    chk("reset start", 32'(spi_txn_start), 32'd0);
    chk("reset data_tx", 32'(spi_data_tx), 32'd0);
    chk("reset ready", 32'(mem_ready), 32'd0);
    chk("reset rdata", 32'(mem_rdata), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed read: byte 4 returns 0x57 + 3 = 0x5A
    run_txn("read1234", 1'b0, 16'h1234, 8'h00, 2, 8'h57);
    chk("read1234 value", 32'(mem_rdata), 32'h5a);
    // Directed write; rdata must keep 0x5A
    run_txn("writeBEEF", 1'b1, 16'hbeef, 8'hc3, 3, 8'h11);

    // Randomized transactions
    for (int n = 0; n < 16; n++) begin
      run_txn($sformatf("rnd%0d", n), 1'($urandom), 16'($urandom), 8'($urandom),
              int'($urandom_range(1, 4)), 8'($urandom));
    end

    // Engine not idle in IDLE: request must wait; then req held high across two transactions
    begin
      int busy_seen;
      clear_logs();
      lat_cfg = 2; key = 8'h40; hold_low = 1'b1;
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h00a5;
      busy_seen = 0;
      repeat (5) begin @(negedge clk); if (busy) busy_seen++; end
      chk("hold idle while engine busy", 32'(busy_seen), 32'd0);
      hold_low = 1'b0;
      wait_ready("heldreq first", 2000);
      @(negedge clk);
      chk("heldreq idle after done", 32'(busy), 32'd0);
      @(negedge clk);
      chk("heldreq reaccept busy", 32'(busy), 32'd1);
      chk("heldreq reaccept cs_n", 32'(spi_cs_n), 32'd0);
      mem_req = 1'b0;
      wait_ready("heldreq second", 2000);
      exp_rdata = 8'h43;
      repeat (3) @(negedge clk);
      @(posedge clk);
      chk("heldreq starts", 32'(tx_q.size()), 32'(2 * (AB + 2)));
      chk("heldreq ready pulses", 32'(ready_cnt), 32'd2);
      chk("heldreq start with cs high", 32'(bad_start), 32'd0);
      chk("heldreq frames", 32'(frame_no), 32'd2);
      chk("heldreq rdata", 32'(mem_rdata), 32'(exp_rdata));
    end

    // Slow engine: 20 cycles per byte, single frame, exactly four starts
    run_txn("slow", 1'b0, 16'h0f0f, 8'h00, 20, 8'h20);
    chk("slow frames", 32'(frame_no), 32'd1);

    // Reset during the third byte of a read
    begin
      int seen;
      clear_logs();
      lat_cfg = 3; key = 8'h70;
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'haaaa;
      @(negedge clk);
      mem_req = 1'b0;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk);
        if (tx_q.size() >= 3) begin seen = 1; break; end
      end
      chk("abort reached byte3", 32'(seen), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort cs_n", 32'(spi_cs_n), 32'd1);
      chk("abort start", 32'(spi_txn_start), 32'd0);
      chk("abort busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("abort no ready", 32'(ready_cnt), 32'd0);
      exp_rdata = 8'h00;
    end
    run_txn("after reset", 1'b0, 16'h0001, 8'h00, 2, 8'h33);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
